sample_streamer: RTL and testbench

Training-sample source that sits directly upstream of the regression datapath.
- Stores a dataset of (x1, x2, t) samples loaded once through a write interface.
- Serves one sample per request to the datapath, which latches it into its x1/x2/t registers.
- Flags end of epoch and rewinds for a new epoch on request.
- Replaces the raw byte-stream reader with a buffered, random-access-free sample store.

---
 rtl/regression_pkg.sv | 28 ++
 rtl/sample_streamer_if.sv | 37 +++
 rtl/sample_streamer_ram.sv | 35 +++
 rtl/sample_streamer.sv | 136 +++++++++++++
 tb/tb_sample_streamer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/regression_pkg.sv
// Shared types and constants for the regression datapath and its sample source.
// A stored sample is one packed word: {t, x2, x1}.
package regression_pkg;

  localparam int X_W      = 7;
  localparam int T_W      = 2;
  localparam int SAMPLE_W = X_W * 2 + T_W;

  localparam logic [T_W-1:0] T_POS = 2'b01;
  localparam logic [T_W-1:0] T_NEG = 2'b11;

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DONE
  } state_t;

  typedef struct packed {
    logic [T_W-1:0] t;
    logic [X_W-1:0] x2;
    logic [X_W-1:0] x1;
  } sample_t;

  function automatic logic t_legal(input logic [T_W-1:0] tv);
    return (tv == T_POS) || (tv == T_NEG);
  endfunction

endpackage

// File: rtl/sample_streamer_if.sv
// Load and serve bus between the sample streamer and its neighbours.
// The slave modport is the streamer's view; master is the driver/consumer side.
interface sample_streamer_if #(
  parameter int ADDR_W  = 7,
  parameter int EPOCH_W = 8
);
  import regression_pkg::*;

  logic                  ld_en;
  logic signed [X_W-1:0] ld_x1;
  logic signed [X_W-1:0] ld_x2;
  logic [T_W-1:0]        ld_t;
  logic                  ld_last;
  logic                  get_data;
  logic                  start_again;

  logic signed [X_W-1:0] x1;
  logic signed [X_W-1:0] x2;
  logic [T_W-1:0]        t;
  logic                  sample_valid;
  logic                  data_finish;
  logic                  loaded;
  logic [ADDR_W:0]       sample_count;
  logic [EPOCH_W-1:0]    epoch;
  logic                  t_err;

  modport master (
    output ld_en, ld_x1, ld_x2, ld_t, ld_last, get_data, start_again,
    input  x1, x2, t, sample_valid, data_finish, loaded, sample_count, epoch, t_err
  );

  modport slave (
    input  ld_en, ld_x1, ld_x2, ld_t, ld_last, get_data, start_again,
    output x1, x2, t, sample_valid, data_finish, loaded, sample_count, epoch, t_err
  );

endinterface

// File: rtl/sample_streamer_ram.sv
// Sample store: one synchronous write port and one registered read port.
// The array itself is never cleared; only the read register resets.
module sample_ram #(
  parameter int DEPTH  = 100,
  parameter int ADDR_W = 7,
  parameter int W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds between reads so the served sample stays stable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sample_streamer.sv
// Buffered training-sample source: load the dataset once, then stream it
// one sample per request, epoch after epoch.
module sample_streamer
  import regression_pkg::*;
#(
  parameter int DEPTH   = 100,
  parameter int ADDR_W  = 7,
  parameter int EPOCH_W = 8
) (
  input logic              clk,
  input logic              rst,
  sample_streamer_if.slave bus
);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     rd_next;
  logic [EPOCH_W-1:0]  epoch_q;
  logic                valid_q, finish_q, loaded_q, terr_q;
  logic                wr_fire, rd_fire, commit, rewind, last_rd;
  sample_t             wr_word, rd_word;

  assign rd_next = {1'b0, rd_ptr} + (ADDR_W+1)'(1);
  assign last_rd = (rd_next == count_q);
  assign wr_word = '{t: bus.ld_t, x2: bus.ld_x2, x1: bus.ld_x1};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LOAD;
    end else begin
      state <= state_nx;
    end
  end

  // Rewind takes priority over a read request in the same cycle.
  always_comb begin
    state_nx = state;
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    commit   = 1'b0;
    rewind   = 1'b0;
    case (state)
      LOAD: begin
        if (bus.ld_en) begin
          wr_fire = 1'b1;
          if (bus.ld_last || (wr_ptr == ADDR_W'(DEPTH - 1))) begin
            commit   = 1'b1;
            state_nx = SERVE;
          end
        end
      end
      SERVE: begin
        if (bus.start_again) begin
          rewind = 1'b1;
        end else if (bus.get_data) begin
          rd_fire = 1'b1;
          if (last_rd) begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        if (bus.start_again) begin
          rewind   = 1'b1;
          state_nx = SERVE;
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      epoch_q  <= '0;
      valid_q  <= 1'b0;
      finish_q <= 1'b0;
      loaded_q <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      valid_q <= rd_fire;
      if (wr_fire) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (!t_legal(bus.ld_t)) begin
          terr_q <= 1'b1;
        end
      end
      if (commit) begin
        count_q  <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
        loaded_q <= 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        if (last_rd) begin
          finish_q <= 1'b1;
        end
      end
      if (rewind) begin
        rd_ptr   <= '0;
        finish_q <= 1'b0;
        if (epoch_q != '1) begin
          epoch_q <= epoch_q + EPOCH_W'(1);
        end
      end
    end
  end

  sample_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .W     (SAMPLE_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_fire),
    .waddr(wr_ptr),
    .wdata(wr_word),
    .re   (rd_fire),
    .raddr(rd_ptr),
    .rdata(rd_word)
  );

  assign bus.x1           = rd_word.x1;
  assign bus.x2           = rd_word.x2;
  assign bus.t            = rd_word.t;
  assign bus.sample_valid = valid_q;
  assign bus.data_finish  = finish_q;
  assign bus.loaded       = loaded_q;
  assign bus.sample_count = count_q;
  assign bus.epoch        = epoch_q;
  assign bus.t_err        = terr_q;

endmodule

// File: tb/tb_sample_streamer.sv
// Self-checking bench: a dataset-level model (a queue of loaded words plus a
// read index) is compared against every DUT output on each falling edge.
module tb_sample_streamer;
  import regression_pkg::*;

  localparam int DEPTH   = 100;
  localparam int ADDR_W  = 7;
  localparam int EPOCH_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sample_streamer_if #(.ADDR_W(ADDR_W), .EPOCH_W(EPOCH_W)) sif ();

  sample_streamer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .EPOCH_W(EPOCH_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  always #5 clk = ~clk;

  logic [15:0] ds[$];
  bit          m_loaded, m_terr, m_finish, m_valid, synced;
  int          m_count, m_issued, m_epoch;
  logic [15:0] m_word;

  // Model: dataset queue, read index into it, and epoch/finish bookkeeping.
  always @(posedge clk) begin
    if (!rst) begin
      ds.delete();
      m_loaded = 0; m_terr = 0; m_finish = 0; m_valid = 0;
      m_count = 0; m_issued = 0; m_epoch = 0; m_word = '0;
      synced = 1;
    end else begin
      m_valid = 0;
      if (!m_loaded) begin
        if (sif.ld_en) begin
          ds.push_back({sif.ld_t, sif.ld_x2, sif.ld_x1});
          if (sif.ld_t == 2'b00 || sif.ld_t == 2'b10) m_terr = 1;
          if (sif.ld_last || ds.size() == DEPTH) begin
            m_loaded = 1;
            m_count  = ds.size();
          end
        end
      end else if (sif.start_again) begin
        m_issued = 0;
        m_finish = 0;
        if (m_epoch < (1 << EPOCH_W) - 1) m_epoch++;
      end else if (sif.get_data && m_issued < m_count) begin
        m_word  = ds[m_issued];
        m_valid = 1;
        m_issued++;
        if (m_issued == m_count) m_finish = 1;
      end
    end
  end

  function automatic logic [31:0] u7(input logic [6:0] v);
    return {25'b0, v};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (synced) begin
      checkOutput("sample_valid", {31'b0, sif.sample_valid}, {31'b0, m_valid});
      checkOutput("x1", u7(sif.x1), u7(m_word[6:0]));
      checkOutput("x2", u7(sif.x2), u7(m_word[13:7]));
      checkOutput("t", {30'b0, sif.t}, {30'b0, m_word[15:14]});
      checkOutput("data_finish", {31'b0, sif.data_finish}, {31'b0, m_finish});
      checkOutput("loaded", {31'b0, sif.loaded}, {31'b0, m_loaded});
      checkOutput("sample_count", 32'(sif.sample_count), 32'(m_count));
      checkOutput("epoch", 32'(sif.epoch), 32'(m_epoch));
      checkOutput("t_err", {31'b0, sif.t_err}, {31'b0, m_terr});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit en, input int a, input int b, input logic [1:0] tt,
                               input bit last, input bit gd, input bit sa);
    sif.ld_en       = en;
    sif.ld_x1       = a[6:0];
    sif.ld_x2       = b[6:0];
    sif.ld_t        = tt;
    sif.ld_last     = last;
    sif.get_data    = gd;
    sif.start_again = sa;
    tick();
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    rst = 1'b1;
  endtask

  function automatic logic [1:0] legalT();
    return ($urandom_range(0, 1) == 0) ? T_POS : T_NEG;
  endfunction

  int          ex1[3] = '{5, -7, 0};
  int          ex2[3] = '{-3, 2, 63};
  logic [1:0]  et[3]  = '{2'b01, 2'b11, 2'b01};

  initial begin
    int strobes;
    int n, written;
    bit en;
    logic [1:0] tt;

    sif.ld_en = 0; sif.ld_x1 = '0; sif.ld_x2 = '0; sif.ld_t = '0;
    sif.ld_last = 0; sif.get_data = 0; sif.start_again = 0;
    doReset();
    checkOutput("reset_loaded", {31'b0, sif.loaded}, 32'd0);
    checkOutput("reset_count", 32'(sif.sample_count), 32'd0);
    checkOutput("reset_x1", u7(sif.x1), 32'd0);

    // Three-sample dataset, last one flagged.
    applyStimulus(1, 5, -3, 2'b01, 0, 0, 0);
    applyStimulus(1, -7, 2, 2'b11, 0, 0, 0);
    applyStimulus(1, 0, 63, 2'b01, 1, 0, 0);
    checkOutput("load3_loaded", {31'b0, sif.loaded}, 32'd1);
    checkOutput("load3_count", 32'(sif.sample_count), 32'd3);
    checkOutput("load3_terr", {31'b0, sif.t_err}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
      checkOutput("stream_valid", {31'b0, sif.sample_valid}, (i < 3) ? 32'd1 : 32'd0);
      checkOutput("stream_finish", {31'b0, sif.data_finish}, (i >= 2) ? 32'd1 : 32'd0);
      if (i < 3) begin
        checkOutput("stream_x1", u7(sif.x1), u7(ex1[i][6:0]));
        checkOutput("stream_x2", u7(sif.x2), u7(ex2[i][6:0]));
        checkOutput("stream_t", {30'b0, sif.t}, {30'b0, et[i]});
      end
    end

    applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);
    checkOutput("rewind_epoch", 32'(sif.epoch), 32'd1);
    checkOutput("rewind_finish", {31'b0, sif.data_finish}, 32'd0);
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("replay_valid", {31'b0, sif.sample_valid}, 32'd1);
    checkOutput("replay_x1", u7(sif.x1), u7(7'd5));
    checkOutput("replay_x2", u7(sif.x2), u7(-7'sd3));

    // Rewind and request together: rewind wins, next request returns sample 0.
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 1);
    checkOutput("both_valid", {31'b0, sif.sample_valid}, 32'd0);
    checkOutput("both_epoch", 32'(sif.epoch), 32'd2);
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("both_next_x1", u7(sif.x1), u7(7'd5));

    repeat (260) applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);
    checkOutput("epoch_saturate", 32'(sif.epoch), 32'd255);

    // Reset mid-stream.
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("midrst_valid", {31'b0, sif.sample_valid}, 32'd0);
    checkOutput("midrst_loaded", {31'b0, sif.loaded}, 32'd0);
    checkOutput("midrst_epoch", 32'(sif.epoch), 32'd0);
    checkOutput("midrst_x1", u7(sif.x1), 32'd0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("postrst_valid", {31'b0, sif.sample_valid}, 32'd0);

    // Full dataset auto-commits at DEPTH; an extra write is ignored.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, $urandom, $urandom, legalT(), 0, 0, 0);
    checkOutput("full_count", 32'(sif.sample_count), 32'd100);
    checkOutput("full_loaded", {31'b0, sif.loaded}, 32'd1);
    applyStimulus(1, 1, 1, 2'b01, 1, 0, 0);
    checkOutput("full_extra", 32'(sif.sample_count), 32'd100);
    strobes = 0;
    for (int i = 0; i < DEPTH + 5; i++) begin
      applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
      if (sif.sample_valid) strobes++;
    end
    checkOutput("full_strobes", 32'(strobes), 32'd100);
    checkOutput("full_finish", {31'b0, sif.data_finish}, 32'd1);

    // Illegal target is stored as-is and flagged stickily.
    doReset();
    applyStimulus(1, 10, -10, 2'b00, 1, 0, 0);
    checkOutput("terr_set", {31'b0, sif.t_err}, 32'd1);
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("terr_t", {30'b0, sif.t}, 32'd0);
    checkOutput("terr_x1", u7(sif.x1), u7(7'd10));
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);
    checkOutput("terr_sticky", {31'b0, sif.t_err}, 32'd1);

    // Randomized datasets and request patterns against the model.
    for (int it = 0; it < 6; it++) begin
      doReset();
      n = $urandom_range(1, 20);
      written = 0;
      for (int c = 0; c < 400 && written < n; c++) begin
        en = ($urandom_range(0, 3) != 0);
        tt = ($urandom_range(0, 9) == 0) ? 2'($urandom) : legalT();
        applyStimulus(en, $urandom, $urandom, tt,
                      en ? (written == n - 1) : bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        if (en) written++;
      end
      for (int c = 0; c < 300; c++)
        applyStimulus(bit'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom),
                      bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                      $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
